// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use / branch / memory-wait hazard controller
// Optional HAZ_PERF_EN builds saturating stall and flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_DIR_W   = 4,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_DIR_W-1:0] id_srcA_dir,
  input  logic [REG_DIR_W-1:0] id_srcB_dir,
  input  logic                 id_useA,
  input  logic                 id_useB,
  input  logic [REG_DIR_W-1:0] ex_dst_dir,
  input  logic                 ex_is_load,
  input  logic                 ex_valid,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  output logic                 pc_hold,
  output logic                 stall_if_id,
  output logic                 stall_id_exe,
  output logic                 stall_exe_mem,
  output logic                 bubble_if_id,
  output logic                 bubble_id_exe,
  output logic                 bubble_mem_wb,
  output logic                 mem_err,
  output logic [15:0]          stall_cycles,
  output logic [15:0]          flush_count
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(MEM_TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          mem_err_nxt;
  logic          lu;
  logic          hazard_en;
  logic          flush;

  assign lu = ex_valid & ex_is_load &
              ((id_useA & (id_srcA_dir == ex_dst_dir)) |
               (id_useB & (id_srcB_dir == ex_dst_dir)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    mem_err_nxt   = mem_err;
    pc_hold       = 1'b0;
    stall_if_id   = 1'b0;
    stall_id_exe  = 1'b0;
    stall_exe_mem = 1'b0;
    bubble_if_id  = 1'b0;
    bubble_id_exe = 1'b0;
    bubble_mem_wb = 1'b0;
    hazard_en     = 1'b0;
    flush         = 1'b0;

    if (state == RUN) begin
      if (mem_req && !mem_ack) begin
        {pc_hold, stall_if_id, stall_id_exe, stall_exe_mem, bubble_mem_wb} = 5'b11111;
        state_nxt    = MEM_WAIT;
        wait_cnt_nxt = CW'(1);
      end else begin
        hazard_en = 1'b1;
      end
    end else if (mem_ack) begin
      state_nxt    = RUN;
      wait_cnt_nxt = '0;
      hazard_en    = 1'b1;
    end else if (wait_cnt < TIMEOUT_CNT) begin
      {pc_hold, stall_if_id, stall_id_exe, stall_exe_mem, bubble_mem_wb} = 5'b11111;
      wait_cnt_nxt = wait_cnt + CW'(1);
    end else begin
      // Abort: release the pipeline and drop the stuck access as a NOP into WB.
      bubble_mem_wb = 1'b1;
      mem_err_nxt   = 1'b1;
      state_nxt     = RUN;
      wait_cnt_nxt  = '0;
      hazard_en     = 1'b1;
    end

    // Branch squashes the ID instruction, so its load-use result is moot.
    if (hazard_en) begin
      if (branch_taken) begin
        bubble_if_id  = 1'b1;
        bubble_id_exe = 1'b1;
        flush         = 1'b1;
      end else if (lu) begin
        pc_hold       = 1'b1;
        stall_if_id   = 1'b1;
        bubble_id_exe = 1'b1;
      end
    end

    // Pipeline registers have no reset; flush NOPs in while rst_n is low.
    if (!rst_n) begin
      pc_hold       = 1'b1;
      stall_if_id   = 1'b0;
      stall_id_exe  = 1'b0;
      stall_exe_mem = 1'b0;
      bubble_if_id  = 1'b1;
      bubble_id_exe = 1'b1;
      bubble_mem_wb = 1'b1;
      flush         = 1'b0;
    end
  end

`ifdef HAZ_PERF_EN
  logic [15:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_hold && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (flush && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 16'd0;
  assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed bench with cycle-by-cycle reference model
module tb_pipeline_hazard_ctrl;

  localparam int RW = 4;
  localparam int TO = 8;

  // Output vector order: {pc_hold, stall_if_id, stall_id_exe, stall_exe_mem,
  //                       bubble_if_id, bubble_id_exe, bubble_mem_wb}
  localparam logic [6:0] V_IDLE   = 7'b0000000;
  localparam logic [6:0] V_RESET  = 7'b1000111;
  localparam logic [6:0] V_MEMSTL = 7'b1111001;
  localparam logic [6:0] V_BRANCH = 7'b0000110;
  localparam logic [6:0] V_LU     = 7'b1100010;
  localparam logic [6:0] V_ABORT  = 7'b0000001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] id_srcA_dir, id_srcB_dir, ex_dst_dir;
  logic          id_useA, id_useB, ex_is_load, ex_valid;
  logic          branch_taken, mem_req, mem_ack;
  logic          pc_hold, stall_if_id, stall_id_exe, stall_exe_mem;
  logic          bubble_if_id, bubble_id_exe, bubble_mem_wb, mem_err;
  logic [15:0]   stall_cycles, flush_count;
  logic [6:0]    dut_vec, exp_vec;

  int n_pass = 0;
  int n_total = 0;
  int m_pend, m_stall, m_flush;
  logic m_err;

  pipeline_hazard_ctrl #(.REG_DIR_W(RW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_srcA_dir(id_srcA_dir), .id_srcB_dir(id_srcB_dir),
    .id_useA(id_useA), .id_useB(id_useB),
    .ex_dst_dir(ex_dst_dir), .ex_is_load(ex_is_load), .ex_valid(ex_valid),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_hold(pc_hold), .stall_if_id(stall_if_id), .stall_id_exe(stall_id_exe),
    .stall_exe_mem(stall_exe_mem), .bubble_if_id(bubble_if_id),
    .bubble_id_exe(bubble_id_exe), .bubble_mem_wb(bubble_mem_wb),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  assign dut_vec = {pc_hold, stall_if_id, stall_id_exe, stall_exe_mem,
                    bubble_if_id, bubble_id_exe, bubble_mem_wb};

  // m_pend = stalled cycles already spent on the outstanding access (0 = none).
  function automatic logic [6:0] model_out(
    input logic rn, input int pend, input logic req, input logic ack,
    input logic br, input logic ld_hazard);
    logic       active;
    logic [6:0] base;
    if (!rn) return V_RESET;
    active = (pend != 0) || req;
    if (active && !ack && pend < TO) return V_MEMSTL;
    base = (active && !ack) ? V_ABORT : V_IDLE;
    if (br) return base | V_BRANCH;
    if (ld_hazard) return base | V_LU;
    return base;
  endfunction

  assign exp_vec = model_out(rst_n, m_pend, mem_req, mem_ack, branch_taken,
                     ex_valid && ex_is_load &&
                     ((id_useA && id_srcA_dir == ex_dst_dir) ||
                      (id_useB && id_srcB_dir == ex_dst_dir)));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend  <= 0;
      m_err   <= 1'b0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      if (((m_pend != 0) || mem_req) && !mem_ack) begin
        if (m_pend < TO) m_pend <= m_pend + 1;
        else begin
          m_pend <= 0;
          m_err  <= 1'b1;
        end
      end else begin
        m_pend <= 0;
      end
      if (exp_vec[6] && m_stall < 65535) m_stall <= m_stall + 1;
      if (exp_vec[2] && m_flush < 65535) m_flush <= m_flush + 1;
    end
  end

  always @(negedge clk) begin
    chk("model_outs", 16'(dut_vec), 16'(exp_vec));
    chk("model_mem_err", 16'(mem_err), 16'(m_err));
`ifdef HAZ_PERF_EN
    chk("model_stall_cycles", stall_cycles, 16'(m_stall));
    chk("model_flush_count", flush_count, 16'(m_flush));
`else
    chk("model_stall_cycles_off", stall_cycles, 16'd0);
    chk("model_flush_count_off", flush_count, 16'd0);
`endif
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    id_srcA_dir = '0; id_srcB_dir = '0; ex_dst_dir = '0;
    id_useA = 0; id_useB = 0; ex_is_load = 0; ex_valid = 0;
    branch_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic set_lu;
    ex_valid = 1; ex_is_load = 1; ex_dst_dir = 4'd5; id_srcA_dir = 4'd5; id_useA = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    #2;
    chk("reset_outs", 16'(dut_vec), 16'(V_RESET));
    chk("reset_mem_err", 16'(mem_err), 16'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1 chk("run_idle", 16'(dut_vec), 16'(V_IDLE));

    tick(); clr(); set_lu();
    #1 chk("lu_hit", 16'(dut_vec), 16'(V_LU));
    tick(); clr();
    #1 chk("lu_one_cycle", 16'(dut_vec), 16'(V_IDLE));
    tick(); clr(); set_lu(); id_useA = 0; id_srcB_dir = 4'd5;
    #1 chk("lu_unused_src", 16'(dut_vec), 16'(V_IDLE));

    for (int i = 0; i < 3; i++) begin
      tick(); clr(); mem_req = 1;
      #1 chk("mem_wait_stall", 16'(dut_vec), 16'(V_MEMSTL));
    end
    tick(); clr(); mem_req = 1; mem_ack = 1;
    #1 chk("mem_ack_cycle", 16'(dut_vec), 16'(V_IDLE));
    tick(); clr();
    #1 chk("mem_wait_no_err", 16'(mem_err), 16'd0);
`ifdef HAZ_PERF_EN
    chk("perf_stall_4", stall_cycles, 16'd4);
`else
    chk("perf_stall_off", stall_cycles, 16'd0);
`endif
    tick(); clr(); mem_req = 1; mem_ack = 1;
    #1 chk("req_ack_same_cycle", 16'(dut_vec), 16'(V_IDLE));

    tick(); clr(); set_lu(); branch_taken = 1;
    #1 chk("branch_over_lu", 16'(dut_vec), 16'(V_BRANCH));
    tick(); clr(); branch_taken = 1;
    #1 chk("branch_plain", 16'(dut_vec), 16'(V_BRANCH));
    tick(); clr();
`ifdef HAZ_PERF_EN
    #1 chk("perf_flush_2", flush_count, 16'd2);
`else
    #1 chk("perf_flush_off", flush_count, 16'd0);
`endif
    tick(); clr(); ex_valid = 1; ex_is_load = 1; id_useB = 1;
    #1 chk("lu_reg0", 16'(dut_vec), 16'(V_LU));

    for (int i = 1; i <= TO; i++) begin
      tick(); clr(); mem_req = 1;
      #1 chk("timeout_stall", 16'(dut_vec), 16'(V_MEMSTL));
    end
    tick(); clr(); mem_req = 1;
    #1 chk("timeout_abort", 16'(dut_vec), 16'(V_ABORT));
    chk("timeout_err_not_yet", 16'(mem_err), 16'd0);
    tick(); clr(); mem_req = 1;
    #1 chk("timeout_err_set", 16'(mem_err), 16'd1);
    tick(); clr(); mem_ack = 1;
    #1 chk("err_sticky", 16'(mem_err), 16'd1);

    tick(); clr(); mem_req = 1; branch_taken = 1;
    #1 chk("branch_in_memstall", 16'(dut_vec), 16'(V_MEMSTL));
    tick(); clr(); branch_taken = 1;
    #1 chk("branch_in_memwait", 16'(dut_vec), 16'(V_MEMSTL));
    tick(); clr(); mem_ack = 1; branch_taken = 1;
    #1 chk("branch_after_release", 16'(dut_vec), 16'(V_BRANCH));

    tick(); clr(); mem_req = 1;
    tick();
    tick();
    #1 chk("memwait_2nd", 16'(dut_vec), 16'(V_MEMSTL));
    rst_n = 1'b0;
    #1 chk("reset_async_outs", 16'(dut_vec), 16'(V_RESET));
    clr();
    tick(); tick();
    rst_n = 1'b1;
    #1 chk("post_reset_run", 16'(dut_vec), 16'(V_IDLE));
    chk("post_reset_err", 16'(mem_err), 16'd0);
    chk("post_reset_stall_cnt", stall_cycles, 16'd0);
    chk("post_reset_flush_cnt", flush_count, 16'd0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the five-stage filter-processor pipeline. It drives the active-high hold inputs (`EN`: 1 = hold, 0 = load) of the IF/ID, ID/EXE and EXE/MEM pipeline registers. It also drives bubble selects that zero the control word entering a register, and the PC hold. It resolves three hazards:
- load-use data hazards;
- taken-branch flushes;
- multi-cycle data-memory accesses, with a timeout watchdog.

## Interface
Parameters:
- `REG_DIR_W`, default 4: register-address width.
- `MEM_TIMEOUT`, default 8: maximum stalled cycles per memory access, ≥1.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `id_srcA_dir`, `id_srcB_dir` in `REG_DIR_W`: source registers of the instruction in ID.
- `id_useA`, `id_useB` in 1: the ID instruction actually reads srcA / srcB.
- `ex_dst_dir` in `REG_DIR_W`: destination register of the instruction in EXE.
- `ex_is_load`, `ex_valid` in 1: EXE holds a valid load.
- `branch_taken` in 1: EXE resolved a taken branch this cycle.
- `mem_req` in 1: the MEM stage is accessing memory this cycle.
- `mem_ack` in 1: memory completes this cycle.
- `pc_hold` out 1: PC keeps its value.
- `stall_if_id`, `stall_id_exe`, `stall_exe_mem` out 1: drive the pipeline-register `EN` inputs.
- `bubble_if_id`, `bubble_id_exe`, `bubble_mem_wb` out 1: the register input mux selects an all-zero control word.
- `mem_err` out 1: sticky memory-timeout flag.
- `stall_cycles` out 16: performance counter (see Configuration).
- `flush_count` out 16: performance counter (see Configuration).

## Operation
- FSM states: `RUN` and `MEM_WAIT`.
  - State, `wait_cnt` (width clog2(`MEM_TIMEOUT`+1)) and `mem_err` are registered.
  - All stall and bubble outputs are combinational from state and inputs.
- Default in `RUN`: every output is 0.
- Load-use detect, `lu`:
  - `lu` = `ex_valid & ex_is_load & ((id_useA & id_srcA_dir==ex_dst_dir) | (id_useB & id_srcB_dir==ex_dst_dir))`.
  - Register 0 is not special.
- Priority in `RUN`: memory stall > branch flush > load-use.
- Memory stall, when `RUN & mem_req & !mem_ack`:
  - Outputs: `pc_hold`=`stall_if_id`=`stall_id_exe`=`stall_exe_mem`=1, `bubble_mem_wb`=1.
  - Next state `MEM_WAIT` with `wait_cnt`=1.
  - `branch_taken` and `lu` are ignored; EXE is frozen, so both are re-evaluated after release.
- `mem_req & mem_ack` in the same `RUN` cycle: no stall.
- In `MEM_WAIT`:
  - `mem_ack`=1: no stall outputs, `bubble_mem_wb`=0; next state `RUN`. The branch and load-use rules apply this cycle as in `RUN`.
  - `!mem_ack` and `wait_cnt<MEM_TIMEOUT`: same outputs as a memory stall; `wait_cnt`++.
  - `!mem_ack` and `wait_cnt==MEM_TIMEOUT` (abort): stall outputs 0, `bubble_mem_wb`=1, `mem_err` set at the next edge, next state `RUN`.
- `mem_err` clears only on reset.
- Branch flush, `branch_taken` with no memory stall:
  - Outputs: `bubble_if_id`=1, `bubble_id_exe`=1, `pc_hold`=0.
  - The `lu` result is discarded, because the ID instruction is squashed.
- Load-use, `lu` with no memory stall and no branch:
  - Outputs: `pc_hold`=1, `stall_if_id`=1, `bubble_id_exe`=1, `stall_id_exe`=0, `stall_exe_mem`=0.
  - Exactly one bubble per load; the next cycle the load is in MEM and `lu` is false.
- Reset (`rst_n`=0, asynchronous, including mid-`MEM_WAIT`):
  - State `RUN`, `wait_cnt`=0, `mem_err`=0, counters 0.
  - Outputs forced: `pc_hold`=1, all stalls 0, all bubbles 1, so NOPs are flushed into the pipeline registers, which have no reset.

## Timing
- Hazard response latency is 0 cycles: outputs react combinationally in the same cycle as the inputs.
- A memory access stalls the pipeline for at most `MEM_TIMEOUT` cycles. The abort happens on cycle `MEM_TIMEOUT`+1, and `mem_err` is visible from the cycle after that.
- Load-use costs exactly 1 cycle. A branch costs 2 squashed instructions and no hold.
- There is no combinational path from any output back to any input.

## Configuration
- `HAZ_PERF_EN` defined:
  - `stall_cycles` counts cycles with `pc_hold`=1 and `rst_n`=1.
  - `flush_count` counts branch-flush cycles.
  - Both saturate at 16'hFFFF and reset to 0.
- `HAZ_PERF_EN` undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Load-use. Stimulus: `ex_valid`=1, `ex_is_load`=1, `ex_dst_dir`=5, `id_srcA_dir`=5, `id_useA`=1. Required: `pc_hold`=`stall_if_id`=`bubble_id_exe`=1 for exactly that cycle. Repeat with `id_useA`=0: no outputs asserted.
- Memory wait, `MEM_TIMEOUT`=8. Stimulus: `mem_req`=1, `mem_ack` low for 3 cycles then high. Required: `stall_exe_mem` and `bubble_mem_wb` high for 3 cycles, all outputs 0 on the ack cycle, `mem_err`=0.
- Timeout, `MEM_TIMEOUT`=8. Stimulus: `mem_req`=1, `mem_ack`=0 forever. Required: 8 stalled cycles, abort cycle 9 with stalls 0 and `bubble_mem_wb`=1, `mem_err`=1 from cycle 10 onward.
- Priority:
  - `branch_taken` and `lu` together: `bubble_if_id`=`bubble_id_exe`=1, `pc_hold`=0.
  - `branch_taken` during a memory stall: stall outputs only, no bubbles.
- Reset during the 2nd `MEM_WAIT` cycle: outputs immediately `pc_hold`=1, bubbles 1, stalls 0. After release: `RUN`, `mem_err`=0, counters 0.
- With `HAZ_PERF_EN`: after the memory-wait scenario plus one load-use, `stall_cycles`=4. After 2 branches, `flush_count`=2. Without the macro, both outputs read 0.
